mfp_gpio_arbiter: RTL

Round-robin arbiter that shares the single GPIO register port (gpio_wd / gpio_we / gpio_rd) of the AHB GPIO peripheral between REQ_COUNT hardware requesters, e.g. the CPU-side bridge and on-chip sequencers.
- Each requester issues single-word read or write transactions with a valid/ready request handshake and receives a one-cycle response pulse.
- Sits between the requesters and the GPIO register bank; it owns sequencing of gpio_we and sampling of gpio_rd.

---
 rtl/mfp_gpio_arb_pkg.sv | 32 +++
 rtl/mfp_gpio_arbiter_if.sv | 36 +++
 rtl/mfp_rr_arbiter.sv | 33 +++
 rtl/mfp_gpio_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/mfp_gpio_arb_pkg.sv
// Shared types and helpers for the GPIO register-port arbiter.
package mfp_gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  // Addresses travel zero-extended to a fixed width so the request struct
  // does not depend on the per-instance index width.
  localparam int ADDR_BITS = 32;

  typedef struct packed {
    logic                 write;
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]          wdata;
  } req_t;

  // Register-index width: wide enough for the larger bank, never below 1.
  function automatic int calc_aw(input int wcount, input int rcount);
    int m;
    m = (wcount > rcount) ? wcount : rcount;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  // Width of a requester index, never below 1.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mfp_gpio_arbiter_if.sv
// Requester handshake plus GPIO register-port signals of the arbiter.
interface mfp_gpio_arbiter_if
  import mfp_gpio_arb_pkg::*;
#(
  parameter int REQ_COUNT   = 2,
  parameter int GPIOW_COUNT = 1,
  parameter int GPIOR_COUNT = GPIOW_COUNT
) ();

  localparam int AW = calc_aw(GPIOW_COUNT, GPIOR_COUNT);

  logic [REQ_COUNT-1:0]           req_valid;
  logic [REQ_COUNT-1:0]           req_write;
  logic [REQ_COUNT-1:0][AW-1:0]   req_addr;
  logic [REQ_COUNT-1:0][31:0]     req_wdata;
  logic [REQ_COUNT-1:0]           req_ready;
  logic [REQ_COUNT-1:0]           rsp_valid;
  logic [31:0]                    rsp_rdata;
  logic                           rsp_err;
  logic [GPIOR_COUNT-1:0][31:0]   gpio_rd;
  logic [31:0]                    gpio_wd;
  logic [GPIOW_COUNT-1:0]         gpio_we;

  // Environment side: requesters and the GPIO register bank.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, gpio_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, gpio_wd, gpio_we
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, gpio_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, gpio_wd, gpio_we
  );

endinterface

// File: rtl/mfp_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module mfp_rr_arbiter
  import mfp_gpio_arb_pkg::*;
#(
  parameter  int REQ_COUNT = 2,
  localparam int PW        = idx_width(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [REQ_COUNT-1:0] grant,
  output logic [PW-1:0]        winner
);

  logic found;
  int   idx;

  // Scan requesters starting at the pointer, wrapping once around.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      idx = (int'(ptr) + k) % REQ_COUNT;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/mfp_gpio_arbiter.sv
// Round-robin arbiter sharing the GPIO register port between requesters.
module mfp_gpio_arbiter
  import mfp_gpio_arb_pkg::*;
#(
  parameter int REQ_COUNT   = 2,
  parameter int GPIOW_COUNT = 1,
  parameter int GPIOR_COUNT = GPIOW_COUNT
) (
  input logic                HCLK,
  input logic                HRESET,
  mfp_gpio_arbiter_if.slave  bus
);

  localparam int PW = idx_width(REQ_COUNT);

  state_t                 state, next_state;
  logic [PW-1:0]          ptr, ptr_next, winner, owner;
  logic [REQ_COUNT-1:0]   grant, owner_onehot;
  logic                   accept;
  req_t                   sel, lat;
  logic [GPIOW_COUNT-1:0] we_dec;
  logic [31:0]            rd_sel;
  logic                   wr_oor, rd_oor;

  mfp_rr_arbiter #(.REQ_COUNT(REQ_COUNT)) u_rr (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner)
  );

  assign accept        = (state == IDLE) && (|bus.req_valid);
  assign bus.req_ready = (accept && !HRESET) ? grant : '0;
  assign bus.gpio_wd   = lat.wdata;
  assign ptr_next      = (int'(winner) == REQ_COUNT - 1) ? '0 : winner + PW'(1);
  assign wr_oor        = lat.addr >= 32'(GPIOW_COUNT);
  assign rd_oor        = lat.addr >= 32'(GPIOR_COUNT);

  // Route the winning requester's fields to the latch inputs.
  always_comb begin
    sel = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (grant[i]) begin
        sel.write = bus.req_write[i];
        sel.addr  = 32'(bus.req_addr[i]);
        sel.wdata = bus.req_wdata[i];
      end
    end
  end

  // Decode write strobe, read-word select and owner response bit.
  always_comb begin
    we_dec       = '0;
    rd_sel       = '0;
    owner_onehot = '0;
    for (int i = 0; i < GPIOW_COUNT; i++) we_dec[i] = (sel.addr == 32'(i));
    for (int i = 0; i < GPIOR_COUNT; i++) if (lat.addr == 32'(i)) rd_sel = bus.gpio_rd[i];
    for (int i = 0; i < REQ_COUNT; i++) owner_onehot[i] = (owner == PW'(i));
  end

  // State register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= next_state;
  end

  // Fixed three-phase sequence: accept, access, respond.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the granted request, drive the strobe, then build the response.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ptr           <= '0;
      owner         <= '0;
      lat           <= '0;
      bus.gpio_we   <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.gpio_we   <= '0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            ptr       <= ptr_next;
            owner     <= winner;
            lat.write <= sel.write;
            lat.addr  <= sel.addr;
            if (sel.write) begin
              lat.wdata   <= sel.wdata;
              bus.gpio_we <= we_dec;
            end
          end
        end
        ISSUE: begin
          bus.rsp_valid <= owner_onehot;
          if (lat.write) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= wr_oor;
          end else begin
            bus.rsp_rdata <= rd_oor ? 32'd0 : rd_sel;
            bus.rsp_err   <= rd_oor;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
